// File: rtl/led_matrix_pkg.sv
// Shared types, constants and frame-size helpers for the LED matrix controller.
// LED_MATRIX_CHECKSUM_EN appends a trailing XOR checksum byte to each frame.
package led_matrix_pkg;

    localparam int BRIGHT_W = 3;

    typedef logic [0:0] scan_state_t;
    localparam scan_state_t ST_BLANK = 1'b0;
    localparam scan_state_t ST_SHOW  = 1'b1;

    function automatic int frame_bits(input int rows, input int cols, input int pwm_bits);
        return rows * cols * 3 * pwm_bits;
    endfunction

    function automatic int rx_bits(input int rows, input int cols, input int pwm_bits);
`ifdef LED_MATRIX_CHECKSUM_EN
        return frame_bits(rows, cols, pwm_bits) + 16;
`else
        return frame_bits(rows, cols, pwm_bits) + 8;
`endif
    endfunction

endpackage

// File: rtl/led_matrix_spi_rx.sv
// SPI mode-0 frame receiver: synchronisers, shift register and frame validation.
// LED_MATRIX_CHECKSUM_EN enables the trailing XOR checksum check.
module led_matrix_spi_rx
    import led_matrix_pkg::*;
#(
    parameter int ROWS     = 8,
    parameter int COLS     = 8,
    parameter int PWM_BITS = 4
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        spi_cs_n,
    input  logic                                        spi_sck,
    input  logic                                        spi_mosi,
    output logic                                        frame_ok,
    output logic                                        frame_err,
    output logic [frame_bits(ROWS, COLS, PWM_BITS)-1:0] frame_data,
    output logic [BRIGHT_W-1:0]                         frame_bright
);

    localparam int FB       = frame_bits(ROWS, COLS, PWM_BITS);
    localparam int RXB      = rx_bits(ROWS, COLS, PWM_BITS);
    localparam int CW       = $clog2(RXB + 1);
    localparam int CTRL_LSB = RXB - FB - 8;

    logic [1:0]     cs_sync_q, cs_sync_d;
    logic [1:0]     sck_sync_q, sck_sync_d;
    logic [1:0]     mosi_sync_q, mosi_sync_d;
    logic           cs_prev_q, cs_prev_d;
    logic           sck_prev_q, sck_prev_d;
    logic           armed_q, armed_d;
    logic           ovr_q, ovr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [RXB-1:0] sr_q, sr_d;
    logic           ok_q, ok_d;
    logic           err_q, err_d;
    logic           cs_s, sck_s, mosi_s;
    logic           cs_fall, cs_rise, sck_rise;
    logic           chk_ok;
`ifdef LED_MATRIX_CHECKSUM_EN
    logic [7:0]     chk_q, chk_d;
`endif

    always_comb begin
        cs_sync_d   = {cs_sync_q[0], spi_cs_n};
        sck_sync_d  = {sck_sync_q[0], spi_sck};
        mosi_sync_d = {mosi_sync_q[0], spi_mosi};
        cs_s        = cs_sync_q[1];
        sck_s       = sck_sync_q[1];
        mosi_s      = mosi_sync_q[1];
        cs_prev_d   = cs_s;
        sck_prev_d  = sck_s;
        cs_fall     = cs_prev_q & ~cs_s;
        cs_rise     = ~cs_prev_q & cs_s;
        sck_rise    = ~sck_prev_q & sck_s;
`ifdef LED_MATRIX_CHECKSUM_EN
        chk_ok      = (chk_q == 8'h00);
        chk_d       = chk_q;
`else
        chk_ok      = 1'b1;
`endif
        armed_d     = armed_q;
        ovr_d       = ovr_q;
        cnt_d       = cnt_q;
        sr_d        = sr_q;
        ok_d        = 1'b0;
        err_d       = 1'b0;

        // Only a frame opened by an observed CS fall may produce a pulse.
        if (cs_fall) begin
            armed_d = 1'b1;
            ovr_d   = 1'b0;
            cnt_d   = '0;
`ifdef LED_MATRIX_CHECKSUM_EN
            chk_d   = 8'h00;
`endif
        end else if (cs_rise) begin
            armed_d = 1'b0;
            if (armed_q) begin
                if (cnt_q == CW'(RXB) && !ovr_q && chk_ok) begin
                    ok_d = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
            end
        end else if (armed_q && !cs_s && sck_rise) begin
            if (cnt_q == CW'(RXB)) begin
                ovr_d = 1'b1;
            end else begin
                sr_d  = {sr_q[RXB-2:0], mosi_s};
                cnt_d = cnt_q + 1'b1;
`ifdef LED_MATRIX_CHECKSUM_EN
                chk_d[~cnt_q[2:0]] = chk_q[~cnt_q[2:0]] ^ mosi_s;
`endif
            end
        end
    end

    // CS resets to the asserted level so a frame in flight at reset is ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_sync_q   <= 2'b00;
            sck_sync_q  <= 2'b00;
            mosi_sync_q <= 2'b00;
            cs_prev_q   <= 1'b0;
            sck_prev_q  <= 1'b0;
            armed_q     <= 1'b0;
            ovr_q       <= 1'b0;
            cnt_q       <= '0;
            sr_q        <= '0;
            ok_q        <= 1'b0;
            err_q       <= 1'b0;
`ifdef LED_MATRIX_CHECKSUM_EN
            chk_q       <= 8'h00;
`endif
        end else begin
            cs_sync_q   <= cs_sync_d;
            sck_sync_q  <= sck_sync_d;
            mosi_sync_q <= mosi_sync_d;
            cs_prev_q   <= cs_prev_d;
            sck_prev_q  <= sck_prev_d;
            armed_q     <= armed_d;
            ovr_q       <= ovr_d;
            cnt_q       <= cnt_d;
            sr_q        <= sr_d;
            ok_q        <= ok_d;
            err_q       <= err_d;
`ifdef LED_MATRIX_CHECKSUM_EN
            chk_q       <= chk_d;
`endif
        end
    end

    assign frame_ok     = ok_q;
    assign frame_err    = err_q;
    assign frame_data   = sr_q[RXB-1 -: FB];
    assign frame_bright = sr_q[CTRL_LSB +: BRIGHT_W];

endmodule

// File: rtl/led_matrix_spi_ctrl.sv
// RGB LED matrix row scanner with PWM, global dimming and SPI double buffer.
// LED_MATRIX_CHECKSUM_EN (in the receiver) adds a frame checksum byte.
module led_matrix_spi_ctrl
    import led_matrix_pkg::*;
#(
    parameter int ROWS      = 8,
    parameter int COLS      = 8,
    parameter int PWM_BITS  = 4,
    parameter int LINE_CYC  = 62500,
    parameter int BLANK_CYC = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            spi_cs_n,
    input  logic            spi_sck,
    input  logic            spi_mosi,
    output logic [ROWS-1:0] row_sel_n,
    output logic [COLS-1:0] col_r,
    output logic [COLS-1:0] col_g,
    output logic [COLS-1:0] col_b,
    output logic            frame_ok,
    output logic            frame_err
);

    localparam int FB       = frame_bits(ROWS, COLS, PWM_BITS);
    localparam int ROW_BITS = COLS * 3 * PWM_BITS;
    localparam int RW       = $clog2(ROWS);
    localparam int SW       = $clog2(LINE_CYC);

    logic [FB-1:0]       rx_data;
    logic [BRIGHT_W-1:0] rx_bright;

    led_matrix_spi_rx #(
        .ROWS     (ROWS),
        .COLS     (COLS),
        .PWM_BITS (PWM_BITS)
    ) u_rx (
        .clk          (clk),
        .rst_n        (rst_n),
        .spi_cs_n     (spi_cs_n),
        .spi_sck      (spi_sck),
        .spi_mosi     (spi_mosi),
        .frame_ok     (frame_ok),
        .frame_err    (frame_err),
        .frame_data   (rx_data),
        .frame_bright (rx_bright)
    );

    scan_state_t         state_q, state_d;
    logic [RW-1:0]       row_q, row_d;
    logic [SW-1:0]       slot_q, slot_d;
    logic [PWM_BITS-1:0] pwm_q, pwm_d;
    logic [2:0]          dim_q, dim_d;
    logic [FB-1:0]       front_q, front_d;
    logic [FB-1:0]       back_q, back_d;
    logic [BRIGHT_W-1:0] bright_q, bright_d;
    logic [BRIGHT_W-1:0] back_bright_q, back_bright_d;
    logic                pend_q, pend_d;
    logic [ROWS-1:0]     row_sel_n_q, row_sel_n_d;
    logic [COLS-1:0]     col_r_q, col_r_d;
    logic [COLS-1:0]     col_g_q, col_g_d;
    logic [COLS-1:0]     col_b_q, col_b_d;
    logic                slot_end, blank_end, row_last, show, lit_en;
    logic [ROW_BITS-1:0] row_v;

    always_comb begin
        slot_end      = (slot_q == SW'(LINE_CYC - 1));
        blank_end     = (slot_q == SW'(BLANK_CYC - 1));
        row_last      = (row_q == RW'(ROWS - 1));
        show          = (state_q == ST_SHOW);
        state_d       = state_q;
        row_d         = row_q;
        slot_d        = slot_end ? '0 : slot_q + 1'b1;
        pwm_d         = show ? pwm_q + 1'b1 : '0;
        dim_d         = (show && pwm_q == '1) ? dim_q + 1'b1 : dim_q;
        front_d       = front_q;
        back_d        = back_q;
        bright_d      = bright_q;
        back_bright_d = back_bright_q;
        pend_d        = pend_q;

        if (slot_end) begin
            state_d = ST_BLANK;
            row_d   = row_last ? '0 : row_q + 1'b1;
        end else if (blank_end) begin
            state_d = ST_SHOW;
        end

        if (slot_end && row_last && pend_q) begin
            front_d  = back_q;
            bright_d = back_bright_q;
            pend_d   = 1'b0;
        end
        // A frame landing on the swap cycle re-arms the swap for the next wrap.
        if (frame_ok) begin
            back_d        = rx_data;
            back_bright_d = rx_bright;
            pend_d        = 1'b1;
        end

        lit_en = show && (dim_q <= bright_q);
        row_v  = '0;
        for (int r = 0; r < ROWS; r++) begin
            row_sel_n_d[r] = !(show && row_q == RW'(r));
            if (row_q == RW'(r)) begin
                row_v = front_q[FB-1-r*ROW_BITS -: ROW_BITS];
            end
        end
        for (int c = 0; c < COLS; c++) begin
            col_r_d[c] = lit_en && (row_v[ROW_BITS-1-(c*3+0)*PWM_BITS -: PWM_BITS] > pwm_q);
            col_g_d[c] = lit_en && (row_v[ROW_BITS-1-(c*3+1)*PWM_BITS -: PWM_BITS] > pwm_q);
            col_b_d[c] = lit_en && (row_v[ROW_BITS-1-(c*3+2)*PWM_BITS -: PWM_BITS] > pwm_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_BLANK;
            row_q         <= '0;
            slot_q        <= '0;
            pwm_q         <= '0;
            dim_q         <= '0;
            front_q       <= '0;
            back_q        <= '0;
            bright_q      <= '1;
            back_bright_q <= '0;
            pend_q        <= 1'b0;
            row_sel_n_q   <= '1;
            col_r_q       <= '0;
            col_g_q       <= '0;
            col_b_q       <= '0;
        end else begin
            state_q       <= state_d;
            row_q         <= row_d;
            slot_q        <= slot_d;
            pwm_q         <= pwm_d;
            dim_q         <= dim_d;
            front_q       <= front_d;
            back_q        <= back_d;
            bright_q      <= bright_d;
            back_bright_q <= back_bright_d;
            pend_q        <= pend_d;
            row_sel_n_q   <= row_sel_n_d;
            col_r_q       <= col_r_d;
            col_g_q       <= col_g_d;
            col_b_q       <= col_b_d;
        end
    end

    assign row_sel_n = row_sel_n_q;
    assign col_r     = col_r_q;
    assign col_g     = col_g_q;
    assign col_b     = col_b_q;

endmodule

// File: tb/tb_led_matrix_spi_ctrl.sv
// Directed bench for led_matrix_spi_ctrl: scan timing, frame accept/reject, PWM and dimming.
// Define LED_MATRIX_CHECKSUM_EN to also cover the checksum path.
module tb_led_matrix_spi_ctrl;

    localparam int ROWS      = 8;
    localparam int COLS      = 2;
    localparam int PWM_BITS  = 4;
    localparam int LINE_CYC  = 472;
    localparam int BLANK_CYC = 24;
    localparam int SHOW_CYC  = LINE_CYC - BLANK_CYC;
    localparam int SCAN      = ROWS * LINE_CYC;
    localparam int PERIODS   = SHOW_CYC / 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic spi_cs_n = 1'b1;
    logic spi_sck = 1'b0;
    logic spi_mosi = 1'b0;
    logic [ROWS-1:0] row_sel_n;
    logic [COLS-1:0] col_r, col_g, col_b;
    logic frame_ok, frame_err;

    always #5 clk = ~clk;

    led_matrix_spi_ctrl #(
        .ROWS      (ROWS),
        .COLS      (COLS),
        .PWM_BITS  (PWM_BITS),
        .LINE_CYC  (LINE_CYC),
        .BLANK_CYC (BLANK_CYC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .spi_cs_n  (spi_cs_n),
        .spi_sck   (spi_sck),
        .spi_mosi  (spi_mosi),
        .row_sel_n (row_sel_n),
        .col_r     (col_r),
        .col_g     (col_g),
        .col_b     (col_b),
        .frame_ok  (frame_ok),
        .frame_err (frame_err)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    int ok_cnt = 0, err_cnt = 0, win_left = 0;
    int c_r0_row0 = 0, c_r0_oth = 0, c_g1_row3 = 0, c_b0 = 0, c_rest = 0;

    always @(negedge clk) begin
        if (frame_ok)  ok_cnt++;
        if (frame_err) err_cnt++;
        if (win_left > 0) begin
            if (col_r[0] && row_sel_n == 8'hFE) c_r0_row0++;
            if (col_r[0] && row_sel_n != 8'hFE) c_r0_oth++;
            if (col_g[1] && row_sel_n == 8'hF7) c_g1_row3++;
            if (col_b[0]) c_b0++;
            if (col_r[1] || col_g[0] || col_b[1] || (col_g[1] && row_sel_n != 8'hF7)) c_rest++;
            win_left--;
        end
    end

    logic [3:0]   px [ROWS][COLS][3];
    logic [255:0] strm;
    int           nbits;

    task automatic fill(input logic [3:0] v);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                for (int ch = 0; ch < 3; ch++) px[r][c][ch] = v;
    endtask

    task automatic build(input logic [2:0] br);
        logic [7:0] ctl;
        strm  = '0;
        nbits = 0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                for (int ch = 0; ch < 3; ch++)
                    for (int b = 3; b >= 0; b--) begin
                        strm = {strm[254:0], px[r][c][ch][b]};
                        nbits++;
                    end
        ctl = {5'b10110, br};
        for (int b = 7; b >= 0; b--) begin
            strm = {strm[254:0], ctl[b]};
            nbits++;
        end
`ifdef LED_MATRIX_CHECKSUM_EN
        ctl = 8'h00;
        for (int k = 0; k < nbits / 8; k++) ctl ^= strm[8*k +: 8];
        for (int b = 7; b >= 0; b--) begin
            strm = {strm[254:0], ctl[b]};
            nbits++;
        end
`endif
    endtask

    task automatic spi_begin();
        @(negedge clk);
        spi_cs_n = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic spi_bit(input logic b);
        spi_mosi = b;
        repeat (4) @(negedge clk);
        spi_sck = 1'b1;
        repeat (4) @(negedge clk);
        spi_sck = 1'b0;
    endtask

    task automatic spi_end();
        repeat (8) @(negedge clk);
        spi_cs_n = 1'b1;
        repeat (16) @(negedge clk);
    endtask

    task automatic send(input int n);
        spi_begin();
        for (int i = 0; i < n; i++) spi_bit(i < nbits ? strm[nbits-1-i] : 1'b1);
        spi_end();
    endtask

    task automatic wait_row0();
        int n = 0;
        while (row_sel_n !== 8'h7F && n < 3 * SCAN) begin
            @(negedge clk);
            n++;
        end
        while (row_sel_n !== 8'hFE && n < 3 * SCAN) begin
            @(negedge clk);
            n++;
        end
        check("wrap_wait", (n < 3 * SCAN), 1);
    endtask

    task automatic measure();
        c_r0_row0 = 0; c_r0_oth = 0; c_g1_row3 = 0; c_b0 = 0; c_rest = 0;
        win_left = SCAN;
        repeat (SCAN + 2) @(negedge clk);
    endtask

    initial begin
        int ok0, err0, lat, n, colbad;
        logic [7:0] e;

        repeat (4) @(negedge clk);
        check("rst_row", row_sel_n, 8'hFF);
        check("rst_cols", {col_r, col_g, col_b}, 0);
        check("rst_ok", frame_ok, 0);
        check("rst_err", frame_err, 0);

        rst_n = 1'b1;
        lat = 0;
        while (row_sel_n != 8'hFE && lat < 1000) begin
            @(negedge clk);
            lat++;
        end
        check("latency", lat, BLANK_CYC + 1);
        colbad = 0;
        for (int r = 0; r < ROWS; r++) begin
            e = ~(8'b1 << r);
            check($sformatf("row%0d", r), row_sel_n, e);
            n = 0;
            while (row_sel_n == e && n < 2000) begin
                if ({col_r, col_g, col_b} != 0) colbad++;
                @(negedge clk);
                n++;
            end
            check($sformatf("show_len%0d", r), n, SHOW_CYC);
            n = 0;
            while (row_sel_n == 8'hFF && n < 2000) begin
                if ({col_r, col_g, col_b} != 0) colbad++;
                @(negedge clk);
                n++;
            end
            check($sformatf("blank_len%0d", r), n, BLANK_CYC);
        end
        check("idle_cols", colbad, 0);

        // Single red pixel at (0,0), full brightness.
        fill(4'd0);
        px[0][0][0] = 4'd15;
        build(3'd7);
        ok0 = ok_cnt; err0 = err_cnt;
        send(nbits);
        check("f1_ok", ok_cnt - ok0, 1);
        check("f1_err", err_cnt - err0, 0);
        wait_row0();
        measure();
        check("f1_r0_row0", c_r0_row0, PERIODS * ROWS * 0 + PERIODS * 15);
        check("f1_r0_oth", c_r0_oth, 0);
        check("f1_rest", c_rest + c_b0 + c_g1_row3, 0);

        // Short, long and extra-byte frames are rejected.
        ok0 = ok_cnt; err0 = err_cnt;
        fill(4'd15);
        build(3'd7);
        send(nbits - 1);
        send(nbits + 1);
        send(nbits + 8);
        check("bad_err", err_cnt - err0, 3);
        check("bad_ok", ok_cnt - ok0, 0);
        wait_row0();
        measure();
        check("bad_r0_row0", c_r0_row0, PERIODS * 15);
        check("bad_rest", c_rest + c_b0, 0);

        // Two frames inside one scan: only the second is shown.
        wait_row0();
        ok0 = ok_cnt;
        fill(4'd0);
        px[2][0][2] = 4'd15;
        build(3'd7);
        send(nbits);
        fill(4'd0);
        px[3][1][1] = 4'd8;
        build(3'd7);
        send(nbits);
        check("dbl_ok", ok_cnt - ok0, 2);
        wait_row0();
        measure();
        check("dbl_g1_row3", c_g1_row3, PERIODS * 8);
        check("dbl_b0", c_b0, 0);
        check("dbl_r0", c_r0_row0 + c_r0_oth, 0);
        check("dbl_rest", c_rest, 0);

        // Brightness 0, all pixels 15: lit 1 in 8 PWM periods.
        fill(4'd15);
        build(3'd0);
        ok0 = ok_cnt;
        send(nbits);
        check("dim_ok", ok_cnt - ok0, 1);
        wait_row0();
        measure();
        check("dim_r0", c_r0_row0 + c_r0_oth, PERIODS * 15);
        check("dim_b0", c_b0, PERIODS * 15);

`ifdef LED_MATRIX_CHECKSUM_EN
        fill(4'd0);
        px[0][0][0] = 4'd15;
        build(3'd7);
        strm[0] = ~strm[0];
        ok0 = ok_cnt; err0 = err_cnt;
        send(nbits);
        check("chk_err", err_cnt - err0, 1);
        check("chk_ok", ok_cnt - ok0, 0);
        wait_row0();
        measure();
        check("chk_b0", c_b0, PERIODS * 15);
`endif

        // Reset in the middle of a frame.
        fill(4'd15);
        build(3'd7);
        ok0 = ok_cnt; err0 = err_cnt;
        spi_begin();
        for (int i = 0; i < 50; i++) spi_bit(strm[nbits-1-i]);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_rst_row", row_sel_n, 8'hFF);
        check("mid_rst_cols", {col_r, col_g, col_b}, 0);
        rst_n = 1'b1;
        for (int i = 50; i < 80; i++) spi_bit(strm[nbits-1-i]);
        spi_end();
        check("mid_rst_ok", ok_cnt - ok0, 0);
        check("mid_rst_err", err_cnt - err0, 0);
        measure();
        check("mid_rst_b0", c_b0, 0);
        check("mid_rst_r0", c_r0_row0 + c_r0_oth, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/led_matrix_spi_ctrl.md
LED_MATRIX_SPI_CTRL -- requirements
Module: led_matrix_spi_ctrl

Interface
REQ-001 SHALL provide parameter ROWS, default 8, number of scanned rows (2..16).
REQ-002 SHALL provide parameter COLS, default 8, number of RGB columns (2..16).
REQ-003 SHALL provide parameter PWM_BITS, default 4, intensity bits per colour channel (1..8).
REQ-004 SHALL provide parameter LINE_CYC, default 62500, clk cycles per row slot (50 MHz / (100 Hz * 8)).
REQ-005 SHALL provide parameter BLANK_CYC, default 64, all-off cycles at start of each row slot (anti-ghost).
REQ-006 clk  in  1  system clock; all logic on its rising edge.
REQ-007 rst_n  in  1  reset, asynchronous, active-low.
REQ-008 spi_cs_n  in  1  SPI chip select, active-low, asynchronous to clk.
REQ-009 spi_sck  in  1  SPI clock, mode 0, at most clk/8.
REQ-010 spi_mosi  in  1  SPI data, MSB first.
REQ-011 row_sel_n  out  ROWS  row enable, active-low, at most one bit low.
REQ-012 col_r / col_g / col_b  out  COLS each  column drive, active-high.
REQ-013 frame_ok  out  1  one-cycle pulse when a frame is accepted.
REQ-014 frame_err  out  1  one-cycle pulse when a frame is discarded.

Function
REQ-015 SHALL pass spi_cs_n, spi_sck and spi_mosi through 2-FF synchronisers; edges SHALL be detected on the synchronised signals.
REQ-016 Frame layout SHALL be FRAME_BITS = ROWS*COLS*3*PWM_BITS pixel bits, then 8 control bits; the total is RX_BITS.
REQ-017 Pixel order SHALL be row 0 col 0 first, channel order R,G,B, each channel MSB first.
REQ-018 Control byte bits [2:0] SHALL be global brightness (0..7); bits [7:3] SHALL be ignored.
REQ-019 A CS falling edge SHALL clear the bit counter and restart reception, discarding any partial frame.
REQ-020 While CS is low, each synchronised SCK rising edge SHALL shift one bit into the back buffer and increment the bit counter.
REQ-021 Bits beyond RX_BITS SHALL NOT be stored; they SHALL mark the frame overrun.
REQ-022 On a CS rising edge with exactly RX_BITS bits received, the block SHALL set swap_pending and pulse frame_ok on the next cycle.
REQ-023 On a CS rising edge with a bit count other than RX_BITS, or with overrun set, the block SHALL pulse frame_err, discard the frame and leave the front buffer unchanged.
REQ-024 Buffer swap SHALL occur only at a row-slot boundary when row index wraps ROWS-1->0; brightness SHALL update in the same cycle.
REQ-025 If a second valid frame completes while swap_pending is set, the newer frame SHALL overwrite the back buffer; only one swap SHALL occur.
REQ-026 Scanner FSM states: BLANK (row_sel_n and all columns off, BLANK_CYC cycles) -> SHOW (remaining LINE_CYC-BLANK_CYC cycles) -> BLANK with the next row; row index SHALL wrap ROWS-1->0.
REQ-027 In SHOW, a PWM counter of PWM_BITS bits SHALL free-run from 0; a channel SHALL be on iff pixel value > pwm_cnt (value 0 never on; the maximum value is on for 2^PWM_BITS-1 of every 2^PWM_BITS counts).
REQ-028 A 3-bit dim counter SHALL increment on each PWM wrap; all columns SHALL be forced off when dim_cnt > brightness (brightness 7 = no dimming).
REQ-029 Outputs SHALL be registered; latency from slot start to row_sel_n asserted SHALL be BLANK_CYC+1 cycles.

Reset
REQ-030 rst_n low SHALL force row_sel_n all-ones, all columns 0, frame_ok and frame_err 0, FSM to BLANK at row 0, both buffers 0, brightness 7 and swap_pending 0.
REQ-031 Reset asserted mid-frame SHALL discard the partial frame; no frame_ok or frame_err SHALL be produced for it.

Configuration
REQ-032 With macro LED_MATRIX_CHECKSUM_EN defined, RX_BITS SHALL include a trailing 8-bit byte equal to the XOR of all preceding bytes; on mismatch the frame SHALL be discarded and frame_err pulsed.
REQ-033 Without LED_MATRIX_CHECKSUM_EN, no checksum byte SHALL be expected, and a frame with an extra byte SHALL be rejected.

Structure
REQ-034 Package led_matrix_pkg SHALL hold the FSM state enum, the RX_BITS/FRAME_BITS functions and the brightness width constant.
REQ-035 SPI synchronisation, shift and frame validation SHALL live in sub-module led_matrix_spi_rx; the scanner/PWM logic SHALL stay in the top module.

Verification
REQ-036 Reset release, no SPI activity -> row_sel_n scans 8'hFE..8'h7F, each slot LINE_CYC cycles, with all columns 0.
REQ-037 Valid frame, pixel(0,0) R=15 and all other pixels 0, brightness 7 -> frame_ok once; after the row-wrap, col_r[0] is high 15 of 16 PWM counts in row 0 only.
REQ-038 Frame truncated 1 bit short, then 1 bit long -> frame_err twice, display unchanged.
REQ-039 Two valid frames within one scan period -> single swap at the wrap, and the second frame is displayed.
REQ-040 Brightness 0 with all pixels 15 -> columns lit for 1 of every 8 PWM periods.
REQ-041 LED_MATRIX_CHECKSUM_EN with a corrupted checksum byte -> frame_err, front buffer retained; rst_n pulsed mid-frame -> outputs return to reset values and no pulses.
